// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_sequencer
//  Description : T-state / M-cycle sequencer for a multi-cycle CPU core.
//                Four T-states per M-cycle and up to MAX_CYCLES M-cycles per
//                instruction. It supports memory-wait stall, HALT parking at
//                the instruction boundary, and a sticky M-cycle overflow flag.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_CYCLES     number of M-cycles tracked (>= 2), width of o_Cycle_Count
//  Ports
//    i_Clk          system clock, rising edge
//    i_Reset_n      asynchronous active-low reset
//    i_Stall        memory wait, freezes all state (highest priority)
//    i_Halt         HALT request, parks the sequencer at the boundary
//    i_IR_Fetch     current M-cycle is the opcode-fetch (last) M-cycle
//    o_Cycle_Step   one-hot T-state, bit0 = T1 ... bit3 = T4
//    o_Cycle_Count  one-hot M-cycle index within the instruction
//    o_IR_Load      strobe: latch the fetched opcode into IR
//    o_Instr_Start  T1 of M-cycle 0 while not halted
//    o_Halted       sequencer is parked by i_Halt
//    o_Seq_Error    sticky M-cycle overflow flag, cleared only by reset
// ============================================================================
module cycle_sequencer #(
   parameter int MAX_CYCLES = 8
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset_n,
   input  logic                  i_Stall,
   input  logic                  i_Halt,
   input  logic                  i_IR_Fetch,
   output logic [3:0]            o_Cycle_Step,
   output logic [MAX_CYCLES-1:0] o_Cycle_Count,
   output logic                  o_IR_Load,
   output logic                  o_Instr_Start,
   output logic                  o_Halted,
   output logic                  o_Seq_Error
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic [3:0]            c_STEP_T1     = 4'b0001;
   localparam logic [MAX_CYCLES-1:0] c_COUNT_FIRST = {{(MAX_CYCLES-1){1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic [3:0]              step_q,  step_d;
   logic [MAX_CYCLES-1:0]   count_q, count_d;
   logic                    err_q,   err_d;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= ST_RUN;
         step_q  <= c_STEP_T1;
         count_q <= c_COUNT_FIRST;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      count_d = count_q;
      err_d   = err_q;

      // Stall freezes everything, so all updates live under !i_Stall.
      if (!i_Stall) begin
         case (state_q)
            ST_RUN: begin
               step_d = {step_q[2:0], step_q[3]};
               // M-cycle bookkeeping happens only on the edge leaving T4;
               // i_IR_Fetch is ignored in T1-T3.
               if (step_q[3]) begin
                  if (i_IR_Fetch) begin
                     count_d = c_COUNT_FIRST;
                     // Halt is honoured only at the instruction boundary.
                     // The rotate above already lands the step on T1.
                     if (i_Halt) begin
                        state_d = ST_HALT;
                     end
                  end else if (count_q[MAX_CYCLES-1]) begin
                     // Saturate at the last M-cycle rather than wrapping to
                     // zero, so the count stays one-hot.
                     err_d = 1'b1;
                  end else begin
                     count_d = count_q << 1;
                  end
               end
            end
            ST_HALT: begin
               // Step and count are already T1 / bit0 and stay there. Leaving
               // halt spends one clock so that T1 of M-cycle 0 then runs in
               // full with o_Instr_Start asserted.
               if (!i_Halt) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign o_Cycle_Step  = step_q;
   assign o_Cycle_Count = count_q;
   assign o_Halted      = (state_q == ST_HALT);
   assign o_Seq_Error   = err_q;
   assign o_IR_Load     = step_q[3] & i_IR_Fetch & ~i_Stall;
   assign o_Instr_Start = step_q[0] & count_q[0] & ~o_Halted;

endmodule
`default_nettype wire

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have one parameter: MAX_CYCLES, default 8, the number of M-cycles tracked and the width of o_Cycle_Count.
REQ-002 The block SHALL have the following ports, clock and reset first:
- i_Clk  input  1  system clock; all state changes on the rising edge.
- i_Reset_n  input  1  reset, asynchronous, active-low.
- i_Stall  input  1  memory wait; freezes all sequencer state.
- i_Halt  input  1  HALT request; holds the sequencer at the instruction boundary.
- i_IR_Fetch  input  1  the current M-cycle is the final (opcode-fetch) M-cycle of the instruction; OR of all microcode fetch outputs.
- o_Cycle_Step  output  4  one-hot T-state within the M-cycle; bit0 = T1 … bit3 = T4.
- o_Cycle_Count  output  MAX_CYCLES  one-hot M-cycle index within the instruction.
- o_IR_Load  output  1  single-cycle strobe: latch the fetched opcode into IR.
- o_Instr_Start  output  1  high at T1 of M-cycle 0 while not halted.
- o_Halted  output  1  the sequencer is parked by i_Halt.
- o_Seq_Error  output  1  sticky flag: M-cycle overflow.
REQ-003 One clock domain; reset SHALL be asynchronous and active-low (i_Reset_n), exactly as stated above.

Function
REQ-004 o_Cycle_Step SHALL rotate left by one position each unstalled clock (0001→0010→0100→1000→0001).
REQ-005 o_Cycle_Count SHALL change only on the clock edge that leaves T4, i.e. at the 1000→0001 step wrap.
REQ-006 At a T4 wrap with i_IR_Fetch=0, o_Cycle_Count SHALL shift left one position.
REQ-007 At a T4 wrap with i_IR_Fetch=1, o_Cycle_Count SHALL return to bit0 (the instruction boundary).
REQ-008 i_IR_Fetch SHALL be sampled only in T4; its value in T1–T3 SHALL have no effect.
REQ-009 o_IR_Load SHALL be combinational: (o_Cycle_Step[3] & i_IR_Fetch & ~i_Stall).
REQ-010 While i_Stall=1, step, count and the halted state SHALL hold, and o_IR_Load SHALL be 0; i_Stall SHALL have priority over every other input.
REQ-011 Overflow: at a T4 wrap with o_Cycle_Count[MAX_CYCLES-1]=1 and i_IR_Fetch=0, the count SHALL hold at the MSB and o_Seq_Error SHALL set; o_Seq_Error SHALL clear only on reset.
REQ-012 Halt entry: if i_Halt=1 at a boundary wrap (REQ-007), the next state SHALL be step 0001, count bit0, o_Halted=1.
REQ-013 While halted, step and count SHALL hold at 0001 / bit0, and o_Instr_Start SHALL be 0.
REQ-014 Halt exit: the first unstalled clock with i_Halt=0 SHALL clear o_Halted; T1 of M-cycle 0 SHALL then run normally, with o_Instr_Start=1 in that cycle.
REQ-015 i_Halt SHALL have no effect outside the boundary wrap and the halted state.
REQ-016 o_Instr_Start SHALL equal (o_Cycle_Step[0] & o_Cycle_Count[0] & ~o_Halted).
REQ-017 Every output SHALL remain one-hot at all times; no all-zero or multi-hot state is permitted, including after reset or overflow.
REQ-018 Minimum instruction length SHALL be one M-cycle (4 clocks), with i_IR_Fetch=1 in M-cycle 0.

Reset
REQ-019 On i_Reset_n=0, asynchronously and regardless of the clock, the block SHALL set:
- o_Cycle_Step = 0001
- o_Cycle_Count = bit0
- o_Halted = 0
- o_Seq_Error = 0
REQ-020 With reset asserted, o_IR_Load SHALL be 0 and o_Instr_Start SHALL be 1.
REQ-021 Reset asserted mid-instruction SHALL abandon it; the first clock after release SHALL advance the step to 0010.

Verification
REQ-022 Two-M-cycle instruction, with i_IR_Fetch=1 only in M-cycle 1 -> count follows 01,01,01,01,10,10,10,10,01; o_IR_Load pulses exactly once, at clock 8.
REQ-023 i_Stall=1 for 3 clocks at T2 of M-cycle 0 -> step holds at 0010 for 3 clocks, then resumes; total instruction length 11 clocks.
REQ-024 i_IR_Fetch held at 0 for 9 M-cycles -> count saturates at 10000000; o_Seq_Error=1 from the 8th T4 wrap onward and stays set.
REQ-025 i_Halt=1 at a boundary wrap, held for 5 clocks -> o_Halted=1, step 0001, count bit0 throughout; after i_Halt=0, the next clock shows o_Instr_Start=1.
REQ-026 i_IR_Fetch=1 during T2 only of a multi-M-cycle instruction -> no boundary is taken; count advances normally at T4.
REQ-027 i_Reset_n pulsed low in T3 of M-cycle 2 -> outputs immediately return to 0001 / bit0 / flags 0, with no clock edge required.
